// File: rtl/mmu_sram_if.sv
// Request/response and external SRAM signals of the MMU + SRAM access controller.
// slave = controller side, master = MEM stage / SRAM side.
interface mmu_sram_if #(
  parameter int ADDR_W = 20
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [31:0]       vaddr_i;
  logic [3:0]        mem_op_i;
  logic [31:0]       store_data_i;
  logic              resp_valid_o;
  logic [31:0]       load_data_o;
  logic              busy_o;
  logic              addr_err_o;
  logic [31:0]       badvaddr_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_data_o;
  logic              sram_data_oe_o;
  logic [31:0]       sram_data_i;
  logic              sram_ce_n_o;
  logic              sram_oe_n_o;
  logic              sram_we_n_o;
  logic [3:0]        sram_be_n_o;

  modport slave (
    input  req_valid_i, vaddr_i, mem_op_i, store_data_i, sram_data_i,
    output req_ready_o, resp_valid_o, load_data_o, busy_o, addr_err_o, badvaddr_o,
           sram_addr_o, sram_data_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o,
           sram_we_n_o, sram_be_n_o
  );

  modport master (
    output req_valid_i, vaddr_i, mem_op_i, store_data_i, sram_data_i,
    input  req_ready_o, resp_valid_o, load_data_o, busy_o, addr_err_o, badvaddr_o,
           sram_addr_o, sram_data_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o,
           sram_we_n_o, sram_be_n_o
  );
endinterface

// File: rtl/mmu_sram_ctrl.sv
// MIPS32 kseg0/kseg1 translation plus multi-cycle asynchronous SRAM sequencer.
// Optional misalignment trap enabled by defining MMU_ALIGN_CHK_EN.
module mmu_sram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  mmu_sram_if.slave bus
);
  localparam int DATA_W = 32;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [3:0] lane_be_n(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_be_n = ~(4'b0001 << a);
      OP_LH, OP_LHU, OP_SH: lane_be_n = a[1] ? 4'b0011 : 4'b1100;
      default:              lane_be_n = 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_rep(input logic [3:0] op, input logic [DATA_W-1:0] d);
    case (op)
      OP_SB:   store_rep = {4{d[7:0]}};
      OP_SH:   store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'd0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  logic [31:0]       paddr;
  logic              op_real, misalign, accept;
  logic [3:0]        op_q;
  logic [1:0]        lane_q;
  logic [3:0]        be_n_q, cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd_q, load_q;
  logic              err_q, resp_q, is_load_q, is_store_q;
  logic              unused_paddr;

  // kseg0/kseg1 map onto the bottom 512 MB; everything else passes through
  always_comb begin
    paddr = bus.vaddr_i;
    if (bus.vaddr_i[31:29] == 3'b100 || bus.vaddr_i[31:29] == 3'b101)
      paddr = {3'b000, bus.vaddr_i[28:0]};
  end
  assign unused_paddr = ^paddr[31:ADDR_W+2];

  assign op_real    = (bus.mem_op_i >= OP_LB) && (bus.mem_op_i <= OP_SW);
  assign accept     = (state == IDLE) && bus.req_valid_i;
  assign is_load_q  = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign is_store_q = (op_q >= OP_SB) && (op_q <= OP_SW);

`ifdef MMU_ALIGN_CHK_EN
  logic [31:0] vaddr_q;
  logic        addr_err_q;
  logic [31:0] badvaddr_q;

  always_comb begin
    misalign = 1'b0;
    case (bus.mem_op_i)
      OP_LH, OP_LHU, OP_SH: misalign = paddr[0];
      OP_LW, OP_SW:         misalign = |paddr[1:0];
      default:              misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) vaddr_q <= bus.vaddr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err_q <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      addr_err_q <= (state == DONE) && err_q;
      if (state == DONE && err_q) badvaddr_q <= vaddr_q;
    end
  end
  assign bus.addr_err_o = addr_err_q;
  assign bus.badvaddr_o = badvaddr_q;
`else
  assign misalign       = 1'b0;
  assign bus.addr_err_o = 1'b0;
  assign bus.badvaddr_o = '0;
`endif

  always_comb begin
    state_nxt          = state;
    bus.req_ready_o    = 1'b0;
    bus.busy_o         = 1'b1;
    bus.sram_ce_n_o    = 1'b1;
    bus.sram_oe_n_o    = 1'b1;
    bus.sram_we_n_o    = 1'b1;
    bus.sram_be_n_o    = 4'hF;
    bus.sram_data_oe_o = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        bus.busy_o      = 1'b0;
        if (bus.req_valid_i) state_nxt = (op_real && !misalign) ? SETUP : DONE;
      end
      SETUP: begin
        bus.sram_ce_n_o    = 1'b0;
        bus.sram_be_n_o    = be_n_q;
        bus.sram_data_oe_o = is_store_q;
        state_nxt          = STROBE;
      end
      STROBE: begin
        bus.sram_ce_n_o    = 1'b0;
        bus.sram_oe_n_o    = !is_load_q;
        bus.sram_we_n_o    = !is_store_q;
        bus.sram_be_n_o    = be_n_q;
        bus.sram_data_oe_o = is_store_q;
        if (cnt_q == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request fields are captured once at accept and held for the whole access
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_real ? bus.mem_op_i : 4'd0;
      lane_q <= paddr[1:0];
      be_n_q <= lane_be_n(bus.mem_op_i, paddr[1:0]);
      err_q  <= op_real && misalign;
    end
    if (state == SETUP)  cnt_q <= '0;
    if (state == STROBE) cnt_q <= cnt_q + 4'd1;
    if (state == STROBE && cnt_q == LAST) rd_q <= bus.sram_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      load_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= paddr[ADDR_W+1:2];
        wdata_q <= store_rep(bus.mem_op_i, bus.store_data_i);
      end
      resp_q <= (state == DONE);
      if (state == DONE && is_load_q && !err_q) load_q <= load_ext(op_q, lane_q, rd_q);
    end
  end

  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_data_o  = wdata_q;
  assign bus.resp_valid_o = resp_q;
  assign bus.load_data_o  = load_q;
endmodule

// File: tb/tb_mmu_sram_ctrl.sv
// Directed bench for mmu_sram_ctrl with default parameters (ADDR_W 20, WAIT_CYCLES 1).
module tb_mmu_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mmu_sram_if #(.ADDR_W(20)) bus ();
  mmu_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, snapshot the SETUP cycle, then count strobes until the response
  task automatic access(input logic [3:0] op, input logic [31:0] va, input logic [31:0] sd,
                        output int resp_at, output int ce_cnt, output int oe_cnt,
                        output int we_cnt, output logic [31:0] addr_t,
                        output logic [3:0] be_t, output logic [31:0] data_t,
                        output logic doe_t);
    bus.req_valid_i  = 1'b1;
    bus.mem_op_i     = op;
    bus.vaddr_i      = va;
    bus.store_data_i = sd;
    step();
    bus.req_valid_i  = 1'b0;
    bus.mem_op_i     = 4'd8;
    bus.vaddr_i      = 32'hFFFF_FFFC;
    bus.store_data_i = 32'h0;
    addr_t  = 32'(bus.sram_addr_o);
    be_t    = bus.sram_be_n_o;
    data_t  = bus.sram_data_o;
    doe_t   = bus.sram_data_oe_o;
    resp_at = -1;
    ce_cnt  = 0;
    oe_cnt  = 0;
    we_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.resp_valid_o) begin
        resp_at = i;
        break;
      end
      if (!bus.sram_ce_n_o) ce_cnt++;
      if (!bus.sram_oe_n_o) oe_cnt++;
      if (!bus.sram_we_n_o) we_cnt++;
      step();
    end
  endtask

  int          r_at, ce_c, oe_c, we_c, resp_seen;
  logic [31:0] a_t, d_t;
  logic [3:0]  be_t;
  logic        doe_t;

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.mem_op_i     = 4'd0;
    bus.vaddr_i      = 32'h0;
    bus.store_data_i = 32'h0;
    bus.sram_data_i  = 32'h0;
    step();
    step();
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_strobes", {29'd0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o}, 32'd7);
    chk("rst_be_n", 32'(bus.sram_be_n_o), 32'hF);
    chk("rst_data_oe", 32'(bus.sram_data_oe_o), 32'd0);
    chk("rst_addr", 32'(bus.sram_addr_o), 32'h0);
    chk("rst_sram_data", bus.sram_data_o, 32'h0);
    chk("rst_resp", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_load", bus.load_data_o, 32'h0);
    chk("rst_err", 32'(bus.addr_err_o), 32'd0);
    chk("rst_badv", bus.badvaddr_o, 32'h0);
    rst = 1'b0;
    step();

    // SW through kseg0
    access(4'd8, 32'h8000_0010, 32'hDEADBEEF, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("sw_addr", a_t, 32'h0000_0004);
    chk("sw_be_n", 32'(be_t), 32'h0);
    chk("sw_data", d_t, 32'hDEADBEEF);
    chk("sw_data_oe", 32'(doe_t), 32'd1);
    chk("sw_we_cycles", 32'(we_c), 32'd2);
    chk("sw_oe_cycles", 32'(oe_c), 32'd0);
    chk("sw_ce_cycles", 32'(ce_c), 32'd3);
    chk("sw_latency", 32'(r_at), 32'd4);
    chk("sw_ready_at_resp", 32'(bus.req_ready_o), 32'd1);
    chk("sw_load_kept", bus.load_data_o, 32'h0);

    // SB through kseg1, byte lane 3
    access(4'd6, 32'hA000_0013, 32'h0000_00A5, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("sb_addr", a_t, 32'h0000_0004);
    chk("sb_be_n", 32'(be_t), 32'h7);
    chk("sb_data", d_t, 32'hA5A5A5A5);
    chk("sb_latency", 32'(r_at), 32'd4);

    // Reset in the middle of a store strobe
    bus.req_valid_i  = 1'b1;
    bus.mem_op_i     = 4'd8;
    bus.vaddr_i      = 32'h0000_0100;
    bus.store_data_i = 32'h1234_5678;
    step();
    bus.req_valid_i = 1'b0;
    step();
    chk("mid_we_low", 32'(bus.sram_we_n_o), 32'd0);
    rst = 1'b1;
    step();
    chk("abort_strobes", {29'd0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o}, 32'd7);
    chk("abort_be_n", 32'(bus.sram_be_n_o), 32'hF);
    chk("abort_data_oe", 32'(bus.sram_data_oe_o), 32'd0);
    chk("abort_idle", 32'(bus.busy_o), 32'd0);
    chk("abort_addr", 32'(bus.sram_addr_o), 32'h0);
    step();
    rst = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid_o) resp_seen++;
      step();
    end
    chk("abort_no_resp", 32'(resp_seen), 32'd0);

    // Byte and halfword loads with extension
    bus.sram_data_i = 32'h0080_0000;
    access(4'd1, 32'h0000_0002, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("lb_data", bus.load_data_o, 32'hFFFF_FF80);
    chk("lb_be_n", 32'(be_t), 32'hB);
    chk("lb_oe_cycles", 32'(oe_c), 32'd2);
    chk("lb_we_cycles", 32'(we_c), 32'd0);
    chk("lb_data_oe", 32'(doe_t), 32'd0);
    access(4'd2, 32'h0000_0002, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("lbu_data", bus.load_data_o, 32'h0000_0080);
    bus.sram_data_i = 32'h8001_0000;
    access(4'd3, 32'h0000_0002, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("lh_data", bus.load_data_o, 32'hFFFF_8001);
    chk("lh_be_n", 32'(be_t), 32'h3);
    bus.sram_data_i = 32'h1234_F00D;
    access(4'd4, 32'h0000_0000, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("lhu_data", bus.load_data_o, 32'h0000_F00D);
    chk("lhu_latency", 32'(r_at), 32'd4);

    // No-op requests, then a word load accepted straight from the response cycle
    access(4'd0, 32'h0000_0040, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("nop_latency", 32'(r_at), 32'd1);
    chk("nop_ce_cycles", 32'(ce_c), 32'd0);
    chk("nop_load_kept", bus.load_data_o, 32'h0000_F00D);
    access(4'd12, 32'h0000_0040, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("op12_latency", 32'(r_at), 32'd1);
    chk("op12_ce_cycles", 32'(ce_c), 32'd0);
    bus.sram_data_i = 32'hAABB_CCDD;
    access(4'd5, 32'h0000_0008, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
    chk("lw_b2b_addr", a_t, 32'h0000_0002);
    chk("lw_b2b_latency", 32'(r_at), 32'd4);
    chk("lw_b2b_data", bus.load_data_o, 32'hAABB_CCDD);

    // Misaligned word load
    bus.sram_data_i = 32'h1122_3344;
    access(4'd5, 32'h0000_0006, 32'h0, r_at, ce_c, oe_c, we_c, a_t, be_t, d_t, doe_t);
`ifdef MMU_ALIGN_CHK_EN
    chk("mis_latency", 32'(r_at), 32'd1);
    chk("mis_ce_cycles", 32'(ce_c), 32'd0);
    chk("mis_err", 32'(bus.addr_err_o), 32'd1);
    chk("mis_badv", bus.badvaddr_o, 32'h0000_0006);
    chk("mis_load_kept", bus.load_data_o, 32'hAABB_CCDD);
`else
    chk("mis_addr", a_t, 32'h0000_0001);
    chk("mis_be_n", 32'(be_t), 32'h0);
    chk("mis_latency", 32'(r_at), 32'd4);
    chk("mis_data", bus.load_data_o, 32'h1122_3344);
    chk("mis_err", 32'(bus.addr_err_o), 32'd0);
`endif
    step();
    chk("resp_one_cycle", 32'(bus.resp_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmu_sram_ctrl.md
Name: mmu_sram_ctrl

Overview:
Parametrised MMU plus SRAM access controller; the next generation of the pipeline's combinational address-mask MMU. Translates MIPS32 virtual addresses (kseg0/kseg1 strip, window mask), decodes the memory op into byte lanes, and runs a multi-cycle SRAM read/write sequence with configurable wait states. Sits between the MEM stage and the external asynchronous SRAM. Returns sign/zero-extended load data with a valid/ready handshake.

Parameters:
ADDR_W, 20, SRAM word-address width; sram_addr_o = paddr[ADDR_W+1:2]
WAIT_CYCLES, 1, extra strobe cycles beyond one (strobe active WAIT_CYCLES+1 cycles); legal 0..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
req_valid_i  in  1  request valid
req_ready_o  out  1  controller can accept request (high only in IDLE)
vaddr_i  in  32  virtual byte address
mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
store_data_i  in  32  store data, right-justified
resp_valid_o  out  1  one-cycle response pulse
load_data_o  out  32  extended load data, held until next response
busy_o  out  1  state != IDLE
addr_err_o  out  1  misaligned-access flag, valid with resp_valid_o
badvaddr_o  out  32  faulting vaddr, valid when addr_err_o
sram_addr_o  out  ADDR_W  SRAM word address
sram_data_o  out  32  SRAM write data
sram_data_oe_o  out  1  drive sram_data_o onto bus
sram_data_i  in  32  SRAM read data
sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low strobes
sram_be_n_o  out  4  active-low byte enables, bit i = byte lane i

Behaviour:
- Reset rst, synchronous, active-high. Reset values: state IDLE, all sram_*_n_o = 1, sram_be_n_o = 4'hF, sram_data_oe_o = 0, sram_addr_o/sram_data_o = 0, resp_valid_o = 0, load_data_o = 0, addr_err_o = 0, badvaddr_o = 0. rst mid-access aborts immediately next edge; no response produced.
- Translation: vaddr[31:29] = 3'b100 or 3'b101 -> paddr = {3'b000, vaddr[28:0]}; else paddr = vaddr. Bits above ADDR_W+1 dropped.
- Lanes (little-endian): byte lane = paddr[1:0]; half lanes = paddr[1]?{3,2}:{1,0}; word all lanes. Store data replicated: SB {4{b}}, SH {2{h}}. Loads: select lane(s), sign-extend LB/LH, zero-extend LBU/LHU.
- FSM: IDLE -> (req_valid_i & ready, op none) DONE; (real op) SETUP. SETUP: addr/be/data latched and driven, ce_n = 0, oe_n = we_n = 1, oe = write. STROBE: oe_n = 0 (load) or we_n = 0 (store) for WAIT_CYCLES+1 cycles via counter; sram_data_i captured on last STROBE cycle. DONE: all strobes high, data_oe = 0, resp_valid_o = 1, load_data_o updated (loads only; stores leave it). DONE -> IDLE.
- Latency: accept at edge t -> resp_valid_o high in cycle starting edge t+WAIT_CYCLES+3. Op none -> resp at t+1, load_data_o unchanged. Throughput: one access per WAIT_CYCLES+4 cycles.
- Inputs sampled only at accept edge; changes while busy ignored.
- Without the optional feature, misalignment ignored: LH/SH use paddr[1], LW/SW ignore paddr[1:0].

Optional Feature:
MMU_ALIGN_CHK_EN: when defined, LH/LHU/SH with paddr[0] = 1, or LW/SW with paddr[1:0] != 0, are accepted, skip SETUP/STROBE (no strobe asserted), go to DONE next cycle with addr_err_o = 1, badvaddr_o = vaddr_i, load_data_o unchanged. Not defined: addr_err_o and badvaddr_o tied 0.

Test Plan:
- Reset: hold rst 2 cycles mid-STROBE of a SW -> next edge all strobes 1, be_n 4'hF, state IDLE, no resp_valid_o.
- SW vaddr 0x8000_0010, data 0xDEADBEEF, WAIT_CYCLES = 1 -> sram_addr 0x00004, be_n 4'h0, we_n low exactly 2 cycles, resp at t+4.
- SB vaddr 0xA000_0013, data 0x000000A5 -> paddr 0x13, be_n 4'h7, sram_data 0xA5A5A5A5.
- LB vs LBU addr 0x2, SRAM returns 0x0080_0000 -> LB 0xFFFFFF80, LBU 0x00000080; LH addr 0x2, SRAM 0x8001_0000 -> 0xFFFF8001.
- op 0 with valid -> resp_valid_o at t+1, no strobe, load_data_o unchanged; back-to-back LW accepted next IDLE.
- MMU_ALIGN_CHK_EN: LW vaddr 0x0000_0006 -> addr_err_o = 1, badvaddr_o 0x00000006, no ce_n low; undefined -> normal word read at sram_addr 0x1.
